// File: rtl/assert_value_monitor.sv
// ---------------------------------------------------------------------------
// assert_value_monitor
//
// Multi-channel runtime value checker. Every rising edge it samples CHANNELS
// buses of WIDTH bits. After arming (en=1) it waits HOLDOFF edges, then flags
// any channel that breaks the rule selected by mode:
//   0 = fail if zero, 1 = fail if equal to ref_val,
//   2 = fail if changed since previous edge, 3 = no check.
// Results: per-channel fail_vec (last check edge only), a sticky flag, a
// saturating count of failing check edges and the first failing channel.
//
// Ports
//   clk         sampling clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          arm; 0 forces IDLE
//   clr         synchronous clear of result registers, suppresses checking
//   mode[1:0]   rule select
//   ref_val     reference value for mode 1
//   data        channel i on bits [i*WIDTH +: WIDTH]
//   armed       high while checking is active (state CHECK)
//   fail_vec    per-channel failure at the last check edge
//   fail_sticky set on any failure, held until clr or reset
//   fail_count  failing check edges, saturating
//   first_ch    lowest failing channel at the first failure since clear
// ---------------------------------------------------------------------------
module assert_value_monitor #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 3,
    parameter int HOLDOFF  = 2,
    parameter int CNT_W    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic [1:0]                mode,
    input  logic [WIDTH-1:0]          ref_val,
    input  logic [CHANNELS*WIDTH-1:0] data,
    output logic                      armed,
    output logic [CHANNELS-1:0]       fail_vec,
    output logic                      fail_sticky,
    output logic [CNT_W-1:0]          fail_count,
    output logic [CH_W-1:0]           first_ch
);

    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                      state, state_nxt;
    logic [HC_W-1:0]             hcnt, hcnt_nxt;
    logic [CHANNELS*WIDTH-1:0]   prev;
    logic [CHANNELS-1:0]         fail;
    logic [CH_W-1:0]             low_idx;
    logic                        check_edge;

    // Per-channel rule. A channel passes only when its value is fully known
    // and satisfies the rule: an X/Z makes the 'known' term unknown, the if
    // falls through to its default and the channel fails, which surfaces
    // undriven buses. For 0/1 values 'known' is constant true.
    function automatic logic chan_fail(input logic [1:0]       m,
                                       input logic [WIDTH-1:0] ch,
                                       input logic [WIDTH-1:0] pv,
                                       input logic [WIDTH-1:0] rv);
        logic ok;
        logic known;
        ok    = 1'b0;
        known = (^ch == 1'b0) || (^ch == 1'b1);
        case (m)
            2'd0:    if (known && (ch != '0)) ok = 1'b1;
            2'd1:    if (known && (ch != rv)) ok = 1'b1;
            2'd2:    if (known && (ch == pv)) ok = 1'b1;
            default: ok = 1'b1;
        endcase
        return !ok;
    endfunction

    // Next-state logic.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        case (state)
            IDLE: begin
                if (en) begin
                    if (HOLDOFF == 0) begin
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = HOLD;
                        hcnt_nxt  = '0;
                    end
                end
            end
            HOLD: begin
                if (!en)                    state_nxt = IDLE;
                else if (hcnt == HOLD_LAST) state_nxt = CHECK;
                else                        hcnt_nxt  = hcnt + 1'b1;
            end
            CHECK: begin
                if (!en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fail = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            fail[i] = chan_fail(mode, data[i*WIDTH +: WIDTH],
                                prev[i*WIDTH +: WIDTH], ref_val);
        end
    end

    // Lowest set index: scan downwards so the last hit is the smallest.
    always_comb begin
        low_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (fail[i]) low_idx = CH_W'(i);
        end
    end

    assign check_edge = (state == CHECK) && en && !clr;
    assign armed      = (state == CHECK);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            prev        <= '0;
            fail_vec    <= '0;
            fail_sticky <= 1'b0;
            fail_count  <= '0;
            first_ch    <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            // prev follows data whenever armed-or-arming, so in CHECK it
            // always holds the previous edge's sample.
            if (en) prev <= data;

            if (clr) begin
                fail_vec    <= '0;
                fail_sticky <= 1'b0;
                fail_count  <= '0;
                first_ch    <= '0;
            end else if (check_edge) begin
                fail_vec <= fail;
                if (|fail) begin
                    fail_sticky <= 1'b1;
                    if (fail_count != '1) fail_count <= fail_count + 1'b1;
                    if (!fail_sticky)     first_ch   <= low_idx;
                end
            end else begin
                fail_vec <= '0;
            end
        end
    end

endmodule
